// File: rtl/svm_linear_classifier_if.sv
// Streaming handshake bundle for svm_linear_classifier: test-vector input
// channel and score/label result channel, both valid/ready.
interface svm_linear_classifier_if #(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 64,
    parameter int NUM_FEAT = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_FEAT*DATA_W-1:0] in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [ACC_W-1:0]           out_score;
    logic                       out_label;

    // Feature source / result collector side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_score, out_label
    );

    // Classifier side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_score, out_label
    );
endinterface

// File: rtl/svm_linear_classifier.sv
// Streaming linear-kernel SVM evaluator. Holds up to MAX_SV support vectors
// with one signed coefficient each plus a bias, and for each accepted test
// vector x produces score = bias + sum_j coef[j]*dot(sv[j], x), one support
// vector per cycle, with label = (score >= 0). One transaction at a time.
module svm_linear_classifier #(
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 64,
    parameter int NUM_FEAT = 16,
    parameter int MAX_SV   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sv_we,
    input  logic [$clog2(MAX_SV)-1:0]    sv_waddr,
    input  logic [NUM_FEAT*DATA_W-1:0]   sv_wdata,
    input  logic [DATA_W-1:0]            coef_wdata,
    input  logic                         bias_we,
    input  logic [ACC_W-1:0]             bias_wdata,
    input  logic                         num_sv_we,
    input  logic [$clog2(MAX_SV+1)-1:0]  num_sv_wdata,
    svm_linear_classifier_if.slave       io,
    output logic                         busy,
    output logic [31:0]                  inst_count
);
    localparam int IW = $clog2(MAX_SV);
    localparam int NW = $clog2(MAX_SV + 1);
    // Full-precision dot product width, then width of dot*coef before wrap
    localparam int PW = 2 * DATA_W + $clog2(NUM_FEAT);
    localparam int TW = PW + DATA_W;
    localparam logic [IW:0]   MAX_SV_A = (IW + 1)'(MAX_SV);
    localparam logic [NW-1:0] MAX_SV_N = NW'(MAX_SV);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_e;

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  x_q    [NUM_FEAT];
    logic signed [DATA_W-1:0]  x_d    [NUM_FEAT];
    logic signed [DATA_W-1:0]  coef_q [MAX_SV];
    logic signed [DATA_W-1:0]  coef_d [MAX_SV];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   bias_q, bias_d;
    logic [NW-1:0]             num_sv_q, num_sv_d;
    logic [NW-1:0]             n_q, n_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [31:0]               inst_q, inst_d;

    // Support-vector storage survives reset; only written from IDLE
    logic signed [DATA_W-1:0]  sv_mem [MAX_SV][NUM_FEAT];
    logic                      sv_wr;

    logic signed [PW-1:0]      dot;
    logic signed [TW-1:0]      term_full;
    logic signed [ACC_W-1:0]   term;

    // Datapath term for the current support vector plus next-state / config logic
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        coef_d   = coef_q;
        acc_d    = acc_q;
        bias_d   = bias_q;
        num_sv_d = num_sv_q;
        n_d      = n_q;
        idx_d    = idx_q;
        inst_d   = inst_q;
        sv_wr    = 1'b0;

        dot = '0;
        for (int f = 0; f < NUM_FEAT; f++) begin
            dot = dot + (PW'(sv_mem[idx_q][f]) * PW'(x_q[f]));
        end
        term_full = TW'(dot) * TW'(coef_q[idx_q]);
        term      = ACC_W'(term_full);

        unique case (state_q)
            IDLE: begin
                if (sv_we && ({1'b0, sv_waddr} < MAX_SV_A)) begin
                    sv_wr            = 1'b1;
                    coef_d[sv_waddr] = coef_wdata;
                end
                if (bias_we) begin
                    bias_d = bias_wdata;
                end
                if (num_sv_we) begin
                    num_sv_d = (num_sv_wdata > MAX_SV_N) ? MAX_SV_N : num_sv_wdata;
                end
                // Accept uses the already-registered config, so a same-cycle
                // write only affects the next transaction
                if (io.in_valid) begin
                    for (int f = 0; f < NUM_FEAT; f++) begin
                        x_d[f] = io.in_data[f*DATA_W +: DATA_W];
                    end
                    n_d     = num_sv_q;
                    acc_d   = bias_q;
                    idx_d   = '0;
                    state_d = (num_sv_q != '0) ? COMPUTE : OUTPUT;
                end
            end
            COMPUTE: begin
                acc_d = acc_q + term;
                if (NW'(idx_q) == n_q - NW'(1)) begin
                    state_d = OUTPUT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            OUTPUT: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                    inst_d  = inst_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and accumulator registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            bias_q   <= '0;
            num_sv_q <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            inst_q   <= '0;
            for (int f = 0; f < NUM_FEAT; f++) x_q[f] <= '0;
            for (int j = 0; j < MAX_SV; j++) coef_q[j] <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            bias_q   <= bias_d;
            num_sv_q <= num_sv_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            inst_q   <= inst_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
        end
    end

    // Support-vector memory write port, not cleared by reset
    always_ff @(posedge clk) begin
        if (rst_n && sv_wr) begin
            for (int f = 0; f < NUM_FEAT; f++) begin
                sv_mem[sv_waddr][f] <= sv_wdata[f*DATA_W +: DATA_W];
            end
        end
    end

    // Result channel is held stable from the registered accumulator while in OUTPUT
    always_comb begin
        io.in_ready  = (state_q == IDLE);
        io.out_valid = (state_q == OUTPUT);
        io.out_score = io.out_valid ? acc_q : '0;
        io.out_label = io.out_valid & ~acc_q[ACC_W-1];
        busy         = (state_q != IDLE);
        inst_count   = inst_q;
    end
endmodule
